// File: rtl/cpu_pkg.sv
// Shared types and sizes for the cpu RAM subsystem.
package cpu_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 16;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line that carries {valid, port} for each issued read until its data returns.
module rd_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic port,
  output logic tail_valid,
  output logic tail_port
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] port_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      port_q  <= '0;
    end else begin
      valid_q[0] <= push;
      port_q[0]  <= port;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        port_q[i]  <= port_q[i-1];
      end
    end
  end

  assign tail_valid = valid_q[DEPTH-1];
  assign tail_port  = port_q[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port RAM: round-robin with bounded hold,
// lock support, and tagged read return.
module ram_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data
);

  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
  localparam bit PREEMPT = (HOLD_MAX != 0);

  owner_t           owner;
  owner_t           last;
  owner_t           other;
  logic [CNT_W-1:0] count;
  logic             own_req;
  logic             own_lock;
  logic             oth_req;
  logic             tail_valid;
  logic             tail_port;

  assign gnt0 = (owner == OWN_P0) && req0;
  assign gnt1 = (owner == OWN_P1) && req1;

  // View of the current owner's request/lock and the competitor, so the FSM is port-agnostic.
  always_comb begin
    own_req  = 1'b0;
    own_lock = 1'b0;
    oth_req  = 1'b0;
    other    = OWN_NONE;
    case (owner)
      OWN_P0: begin
        own_req  = req0;
        own_lock = lock0;
        oth_req  = req1;
        other    = OWN_P1;
      end
      OWN_P1: begin
        own_req  = req1;
        own_lock = lock1;
        oth_req  = req0;
        other    = OWN_P0;
      end
      default: ;
    endcase
  end

  // Count saturates at CNT_TOP so a late competitor preempts on the owner's next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_NONE;
      last  <= OWN_P1;
      count <= '0;
    end else begin
      case (owner)
        OWN_NONE: begin
          count <= '0;
          if (req0 && (!req1 || last == OWN_P1)) begin
            owner <= OWN_P0;
            last  <= OWN_P0;
          end else if (req1) begin
            owner <= OWN_P1;
            last  <= OWN_P1;
          end
        end
        default: begin
          if (own_lock) begin
            if (own_req && count != CNT_TOP) count <= count + CNT_W'(1);
          end else if (!own_req) begin
            count <= '0;
            owner <= oth_req ? other : OWN_NONE;
            if (oth_req) last <= other;
          end else if (PREEMPT && count == CNT_TOP && oth_req) begin
            count <= '0;
            owner <= other;
            last  <= other;
          end else if (count != CNT_TOP) begin
            count <= count + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    ram_w_en   = 1'b0;
    ram_addr   = '0;
    ram_w_data = '0;
    if (gnt0) begin
      ram_w_en   = we0;
      ram_addr   = addr0;
      ram_w_data = wdata0;
    end else if (gnt1) begin
      ram_w_en   = we1;
      ram_addr   = addr1;
      ram_w_data = wdata1;
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       ((gnt0 && !we0) || (gnt1 && !we1)),
    .port       (gnt1),
    .tail_valid (tail_valid),
    .tail_port  (tail_port)
  );

  assign rvalid0 = tail_valid && !tail_port;
  assign rvalid1 = tail_valid && tail_port;
  assign rdata   = ram_r_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a transaction-level arbitration model predicts grants
// and RAM traffic, and queues expected read returns for an independent rvalid monitor.
module tb_ram_arbiter;
  import cpu_pkg::*;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int RD_LAT   = 1;
  localparam int HOLD_MAX = 4;

  typedef struct {
    int                port;
    logic [DATA_W-1:0] data;
    int                due;
  } rd_exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req [2];
  logic              we [2];
  logic              lock [2];
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wdata [2];
  logic              gnt0, gnt1, rvalid0, rvalid1, ram_w_en;
  logic [DATA_W-1:0] rdata, ram_w_data, ram_r_data, rd_q;
  logic [ADDR_W-1:0] ram_addr;

  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] ref_mem [256];
  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  rd_exp_t exp_q [$];
  rd_exp_t mon_e;
  int      cyc = 0;
  int      n_cmp = 0;
  int      n_fail = 0;
  int      m_owner, m_last, m_tenure;
  bit      last_g [2];
  int      obs_g0, obs_g1;

  ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .HOLD_MAX(HOLD_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .lock0(lock[0]), .lock1(lock[1]), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM with a one-cycle registered read.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_w_en) mem[ram_addr] <= ram_w_data;
    rd_q <= mem[ram_addr];
  end
  assign ram_r_data = rd_q;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int p, input bit r, input bit w, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input bit l);
    req[p]   = r;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    lock[p]  = l;
  endtask

  task automatic modelReset();
    m_owner  = -1;
    m_last   = 1;
    m_tenure = 0;
    last_g[0] = 0;
    last_g[1] = 0;
  endtask

  // One cycle: predict and check grant/RAM traffic, queue read returns, advance the model.
  task automatic stepCycle();
    bit g [2];
    int p, o, nxt;
    logic              ew;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    #2;
    g[0] = (m_owner == 0) && req[0];
    g[1] = (m_owner == 1) && req[1];
    checkOutput("gnt0", 32'(gnt0), 32'(g[0]));
    checkOutput("gnt1", 32'(gnt1), 32'(g[1]));
    obs_g0 += int'(gnt0);
    obs_g1 += int'(gnt1);
    if (g[0] || g[1]) begin
      p  = g[1] ? 1 : 0;
      ew = we[p];
      ea = addr[p];
      ed = wdata[p];
      if (ew) ref_mem[ea] = ed;
      else exp_q.push_back('{port: p, data: ref_mem[ea], due: cyc + RD_LAT});
    end else begin
      ew = 1'b0;
      ea = '0;
      ed = '0;
    end
    checkOutput("ram_w_en", 32'(ram_w_en), 32'(ew));
    checkOutput("ram_addr", 32'(ram_addr), 32'(ea));
    checkOutput("ram_w_data", 32'(ram_w_data), 32'(ed));
    nxt = m_owner;
    if (m_owner < 0) begin
      if (req[0] && req[1]) nxt = 1 - m_last;
      else if (req[0]) nxt = 0;
      else if (req[1]) nxt = 1;
    end else begin
      p = m_owner;
      o = 1 - p;
      if (g[p]) m_tenure++;
      if (!lock[p]) begin
        if (!req[p]) nxt = req[o] ? o : -1;
        else if (HOLD_MAX != 0 && m_tenure >= HOLD_MAX && req[o]) nxt = o;
      end
    end
    if (nxt != m_owner) begin
      m_tenure = 0;
      if (nxt >= 0) m_last = nxt;
      m_owner = nxt;
    end
    last_g[0] = g[0];
    last_g[1] = g[1];
    @(posedge clk);
    #1;
  endtask

  task automatic idleAll(input int n);
    for (int p = 0; p < 2; p++) applyStimulus(p, 0, 0, '0, '0, 0);
    repeat (n) stepCycle();
  endtask

  // Both ports keep reading; a port issues a fresh address only after its grant.
  task automatic holdBoth(input int n, input bit lk0);
    for (int k = 0; k < n; k++) begin
      for (int p = 0; p < 2; p++)
        if (!req[p] || last_g[p])
          applyStimulus(p, 1, 0, 8'($urandom), 16'($urandom), (p == 0) ? lk0 : 1'b0);
      lock[0] = lk0;
      stepCycle();
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_gnt0", 32'(gnt0), 32'd0);
    checkOutput("rst_gnt1", 32'(gnt1), 32'd0);
    checkOutput("rst_rvalid0", 32'(rvalid0), 32'd0);
    checkOutput("rst_rvalid1", 32'(rvalid1), 32'd0);
    checkOutput("rst_ram_w_en", 32'(ram_w_en), 32'd0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst_ram_w_data", 32'(ram_w_data), 32'd0);
    exp_q.delete();
    modelReset();
    for (int p = 0; p < 2; p++) applyStimulus(p, 0, 0, '0, '0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Read-return monitor: an rvalid must appear exactly when a queued read falls due.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      checkOutput("rvalid0", 32'(rvalid0), 32'(mon_e.port == 0));
      checkOutput("rvalid1", 32'(rvalid1), 32'(mon_e.port == 1));
      checkOutput("rdata", 32'(rdata), 32'(mon_e.data));
    end else begin
      checkOutput("rvalid0_idle", 32'(rvalid0), 32'd0);
      checkOutput("rvalid1_idle", 32'(rvalid1), 32'd0);
    end
  end

  initial begin
    for (int p = 0; p < 2; p++) applyStimulus(p, 0, 0, '0, '0, 0);
    modelReset();
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = (i == 8'h10) ? 16'hBEEF : 16'($urandom);
      pre_addr = 8'(i);
      pre_data = ref_mem[i];
      pre_en   = 1'b1;
      @(posedge clk);
      #1;
    end
    pre_en = 1'b0;
    doReset();

    $display("[TB] single read from 0x10");
    applyStimulus(0, 1, 0, 8'h10, '0, 0);
    obs_g0 = 0;
    obs_g1 = 0;
    stepCycle();
    checkOutput("first_req_bubble", 32'(obs_g0), 32'd0);
    stepCycle();
    applyStimulus(0, 0, 0, '0, '0, 0);
    idleAll(3);

    $display("[TB] both ports contend for 20 cycles");
    obs_g0 = 0;
    obs_g1 = 0;
    holdBoth(20, 0);
    checkOutput("contend_busy", 32'(obs_g0 + obs_g1), 32'd19);
    idleAll(2);

    $display("[TB] lock held by port 0");
    applyStimulus(0, 1, 0, 8'($urandom), '0, 1);
    stepCycle();
    obs_g0 = 0;
    obs_g1 = 0;
    holdBoth(12, 1);
    checkOutput("lock_gnt1", 32'(obs_g1), 32'd0);
    checkOutput("lock_gnt0", 32'(obs_g0), 32'd12);
    holdBoth(4, 0);
    idleAll(2);

    $display("[TB] port 1 writes, port 0 reads back");
    applyStimulus(1, 1, 1, 8'h20, 16'h1234, 0);
    repeat (2) stepCycle();
    applyStimulus(1, 0, 0, '0, '0, 0);
    applyStimulus(0, 1, 0, 8'h20, '0, 0);
    repeat (2) stepCycle();
    idleAll(3);

    $display("[TB] reset during a read, then tie");
    applyStimulus(0, 1, 0, 8'h10, '0, 0);
    repeat (2) stepCycle();
    doReset();
    applyStimulus(0, 1, 0, 8'($urandom), '0, 0);
    applyStimulus(1, 1, 0, 8'($urandom), '0, 0);
    obs_g0 = 0;
    obs_g1 = 0;
    repeat (2) stepCycle();
    checkOutput("tie_gnt0", 32'(obs_g0), 32'd1);
    checkOutput("tie_gnt1", 32'(obs_g1), 32'd0);
    idleAll(3);

    $display("[TB] random traffic");
    for (int k = 0; k < 2500; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || last_g[p])
          applyStimulus(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        8'($urandom), 16'($urandom), lock[p]);
        if ($urandom_range(0, 19) == 0) lock[p] = ~lock[p];
      end
      stepCycle();
    end
    idleAll(RD_LAT + 3);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
